// File: rtl/mmio_pkg.sv
// mmio_pkg: address map, control-register layout and helpers shared by the input responder
package mmio_pkg;
  localparam int DBITS = 32;
  localparam logic [DBITS-1:0] ADDR_KEY   = 32'hF000_0010;
  localparam logic [DBITS-1:0] ADDR_SW    = 32'hF000_0014;
  localparam logic [DBITS-1:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [DBITS-1:0] ADDR_SCTRL = 32'hF000_0114;
  localparam int READY = 0;
  localparam int OVERRUN = 2;
  localparam int IE = 4;
  typedef struct packed {
    logic ie;
    logic overrun;
    logic ready;
  } dev_stat_t;
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction
  // A change event outranks the write-clear of overrun; a data read clears ready unless an event lands
  function automatic dev_stat_t stat_next(input dev_stat_t s, input logic ev, input logic rd,
                                          input logic wr, input logic [DBITS-1:0] wd);
    dev_stat_t n;
    n.ready = ev | (s.ready & ~rd);
    n.overrun = (ev & s.ready & ~rd) | (s.overrun & ~(wr & ~wd[OVERRUN]));
    n.ie = wr ? wd[IE] : s.ie;
    return n;
  endfunction
  function automatic logic [DBITS-1:0] ctrl_word(input dev_stat_t s);
    logic [DBITS-1:0] w;
    w = '0;
    w[READY] = s.ready;
    w[OVERRUN] = s.overrun;
    w[IE] = s.ie;
    return w;
  endfunction
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: 2-FF synchronizer and per-bit stability filter with a same-cycle change pulse
module input_debouncer
  import mmio_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CYCLES = 4,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);
  localparam int CW = cnt_width(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  logic [WIDTH-1:0] meta_q, sync_q, sync_v, stable_d, stable_q;
  logic [WIDTH-1:0][CW-1:0] cnt_d, cnt_q;
  always_comb begin
    sync_v = INVERT ? ~sync_q : sync_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = (sync_v[i] != stable_q[i] && cnt_q[i] != LAST) ? cnt_q[i] + CW'(1) : '0;
      stable_d[i] = (sync_v[i] != stable_q[i] && cnt_q[i] == LAST) ? sync_v[i] : stable_q[i];
    end
  end
  // Synchronizers reset to the raw idle level so an inverted input starts out released
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= {WIDTH{INVERT}};
      sync_q <= {WIDTH{INVERT}};
      stable_q <= '0;
      cnt_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
  end
  assign stable = stable_q;
  assign changed = |(stable_d ^ stable_q);
endmodule

// File: rtl/mmio_input_responder.sv
// mmio_input_responder: bus responder for debounced KEY/SW with status registers and one-cycle read latency
module mmio_input_responder
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata,
  output logic             rd_hit,
  output logic             irq
);
  logic [3:0] key_stable;
  logic [9:0] sw_stable;
  logic k_ev, s_ev, rd_hit_d, rd_hit_q;
  logic [DBITS-1:0] rdata_d, rdata_q;
  dev_stat_t k_d, k_q, s_d, s_q;
  input_debouncer #(.WIDTH(4), .CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b1)) u_key (
    .clk(clk), .reset(reset), .raw(KEY), .stable(key_stable), .changed(k_ev)
  );
  input_debouncer #(.WIDTH(10), .CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b0)) u_sw (
    .clk(clk), .reset(reset), .raw(SW), .stable(sw_stable), .changed(s_ev)
  );
  // Read data is taken from pre-update state, so a clearing read still reports what it cleared
  always_comb begin
    k_d = stat_next(k_q, k_ev, rd_en && addr == ADDR_KEY, wr_en && addr == ADDR_KCTRL, wdata);
    s_d = stat_next(s_q, s_ev, rd_en && addr == ADDR_SW, wr_en && addr == ADDR_SCTRL, wdata);
    rdata_d = !rd_en              ? '0 :
              addr == ADDR_KEY    ? DBITS'(key_stable) :
              addr == ADDR_SW     ? DBITS'(sw_stable) :
              addr == ADDR_KCTRL  ? ctrl_word(k_q) :
              addr == ADDR_SCTRL  ? ctrl_word(s_q) : '0;
    rd_hit_d = rd_en && (addr == ADDR_KEY || addr == ADDR_SW ||
                         addr == ADDR_KCTRL || addr == ADDR_SCTRL);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q <= '0;
      s_q <= '0;
      rdata_q <= '0;
      rd_hit_q <= 1'b0;
    end else begin
      k_q <= k_d;
      s_q <= s_d;
      rdata_q <= rdata_d;
      rd_hit_q <= rd_hit_d;
    end
  end
  assign rdata = rdata_q;
  assign rd_hit = rd_hit_q;
  assign irq = (k_q.ready & k_q.ie) | (s_q.ready & s_q.ie);
endmodule

// File: tb/tb_mmio_input_responder.sv
// tb_mmio_input_responder: directed vector table plus randomized traffic against a window-based reference model
module tb_mmio_input_responder;
  import mmio_pkg::*;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b1, rd_en = 1'b0, wr_en = 1'b0;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SW = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic rd_hit, irq;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  mmio_input_responder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .addr(addr), .rd_en(rd_en),
    .wr_en(wr_en), .wdata(wdata), .rdata(rdata), .rd_hit(rd_hit), .irq(irq)
  );
  // Reference model: a bit settles when its synchronized value has disagreed with the
  // accepted value for each of the last D cycles; raw samples are kept as plain history
  logic [9:0] kh[$], sh[$];
  logic [3:0] mk;
  logic [9:0] ms;
  logic k_rdy, k_ovr, k_ie, s_rdy, s_ovr, s_ie, m_hit, m_irq;
  logic [31:0] m_rdata;
  function automatic logic [9:0] settle(input logic [9:0] st, input bit is_key);
    logic [9:0] n;
    logic [9:0] v;
    bit all;
    n = st;
    for (int b = 0; b < 10; b++) begin
      all = 1;
      for (int k = 0; k < D; k++) begin
        v = is_key ? kh[kh.size() - 2 - k] : sh[sh.size() - 2 - k];
        if (v[b] == st[b]) all = 0;
      end
      if (all) n[b] = ~st[b];
    end
    return n;
  endfunction
  task automatic model(input logic rs, input logic [3:0] k, input logic [9:0] s, input logic rd,
                       input logic wr, input logic [31:0] a, input logic [31:0] wd);
    logic [3:0] nk;
    logic [9:0] ns;
    logic kev, sev, rk, rs_, kw, sw_w;
    if (rs) begin
      mk = '0; ms = '0;
      {k_rdy, k_ovr, k_ie, s_rdy, s_ovr, s_ie} = '0;
      m_rdata = '0; m_hit = 0; m_irq = 0;
      kh.delete(); sh.delete();
      for (int i = 0; i < D + 2; i++) begin kh.push_back('0); sh.push_back('0); end
      return;
    end
    nk = 4'(settle({6'h0, mk}, 1));
    ns = settle(ms, 0);
    kev = nk != mk; sev = ns != ms;
    rk = rd && a == ADDR_KEY; rs_ = rd && a == ADDR_SW;
    kw = wr && a == ADDR_KCTRL; sw_w = wr && a == ADDR_SCTRL;
    m_hit = rd && (a == ADDR_KEY || a == ADDR_SW || a == ADDR_KCTRL || a == ADDR_SCTRL);
    if (!rd) m_rdata = 0;
    else if (a == ADDR_KEY) m_rdata = {28'h0, mk};
    else if (a == ADDR_SW) m_rdata = {22'h0, ms};
    else if (a == ADDR_KCTRL) m_rdata = {27'h0, k_ie, 1'b0, k_ovr, 1'b0, k_rdy};
    else if (a == ADDR_SCTRL) m_rdata = {27'h0, s_ie, 1'b0, s_ovr, 1'b0, s_rdy};
    else m_rdata = 0;
    if (kw && !wd[2]) k_ovr = 0;
    if (kev && k_rdy && !rk) k_ovr = 1;
    if (rk) k_rdy = 0;
    if (kev) k_rdy = 1;
    if (kw) k_ie = wd[4];
    if (sw_w && !wd[2]) s_ovr = 0;
    if (sev && s_rdy && !rs_) s_ovr = 1;
    if (rs_) s_rdy = 0;
    if (sev) s_rdy = 1;
    if (sw_w) s_ie = wd[4];
    mk = nk; ms = ns;
    m_irq = (k_rdy & k_ie) | (s_rdy & s_ie);
    kh.push_back({6'h0, ~k}); sh.push_back(s);
    void'(kh.pop_front()); void'(sh.pop_front());
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic step(input logic rs, input logic [3:0] k, input logic [9:0] s, input logic rd,
                      input logic wr, input logic [31:0] a, input logic [31:0] wd);
    reset = rs; KEY = k; SW = s; rd_en = rd; wr_en = wr; addr = a; wdata = wd;
    model(rs, k, s, rd, wr, a, wd);
    @(posedge clk);
    #1;
    check("model rdata", rdata, m_rdata);
    check("model rd_hit", {31'h0, rd_hit}, {31'h0, m_hit});
    check("model irq", {31'h0, irq}, {31'h0, m_irq});
  endtask
  typedef struct {
    logic rs; logic [3:0] k; logic [9:0] s; int op; logic [31:0] a, wd;
    int reps; bit chk; logic [31:0] ex; logic eh, ei;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t v(input logic rs, input logic [3:0] k, input logic [9:0] s, input int op,
                             input logic [31:0] a, input logic [31:0] wd, input int reps, input bit chk,
                             input logic [31:0] ex, input logic eh, input logic ei);
    vec_t r;
    r.rs = rs; r.k = k; r.s = s; r.op = op; r.a = a; r.wd = wd;
    r.reps = reps; r.chk = chk; r.ex = ex; r.eh = eh; r.ei = ei;
    return r;
  endfunction
  localparam logic [31:0] AK = ADDR_KEY, AS = ADDR_SW, AKC = ADDR_KCTRL, ASC = ADDR_SCTRL;
  initial begin
    logic [3:0] rk;
    logic [9:0] rsw;
    logic [31:0] amap[5];
    // op: 0 idle, 1 read, 2 write
    tv.push_back(v(0, 4'hF, 10'h0,   1, AK,  0, 1, 1, 0, 1, 0));
    tv.push_back(v(0, 4'hF, 10'h0,   1, AS,  0, 1, 1, 0, 1, 0));
    tv.push_back(v(0, 4'hF, 10'h0,   1, AKC, 0, 1, 1, 0, 1, 0));
    tv.push_back(v(0, 4'hF, 10'h0,   1, 32'hF000_0020, 0, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 0, 0,   0, 5, 0, 0, 0, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 1, ASC, 0, 1, 1, 0, 1, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 1, ASC, 0, 1, 1, 1, 1, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 1, AS,  0, 1, 1, 32'h2A5, 1, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 1, ASC, 0, 1, 1, 0, 1, 0));
    tv.push_back(v(0, 4'hD, 10'h2A5, 0, 0,   0, 3, 0, 0, 0, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 0, 0,   0, 8, 0, 0, 0, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 1, AKC, 0, 1, 1, 0, 1, 0));
    tv.push_back(v(0, 4'hD, 10'h2A5, 0, 0,   0, 10, 0, 0, 0, 0));
    tv.push_back(v(0, 4'hD, 10'h2A5, 1, AK,  0, 1, 1, 2, 1, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 0, 0,   0, 8, 0, 0, 0, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 1, AK,  0, 1, 1, 0, 1, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 2, AKC, 32'h10, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'hE, 10'h2A5, 0, 0,   0, 5, 1, 0, 0, 0));
    tv.push_back(v(0, 4'hE, 10'h2A5, 0, 0,   0, 1, 1, 0, 0, 1));
    tv.push_back(v(0, 4'hE, 10'h2A5, 1, AK,  0, 1, 1, 1, 1, 0));
    tv.push_back(v(0, 4'hE, 10'h2A5, 2, AKC, 0, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 0, 0,   0, 7, 0, 0, 0, 0));
    tv.push_back(v(0, 4'hB, 10'h2A5, 0, 0,   0, 7, 0, 0, 0, 0));
    tv.push_back(v(0, 4'hB, 10'h2A5, 1, AKC, 0, 1, 1, 5, 1, 0));
    tv.push_back(v(0, 4'hB, 10'h2A5, 2, AKC, 4, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'hB, 10'h2A5, 1, AKC, 0, 1, 1, 5, 1, 0));
    tv.push_back(v(0, 4'hB, 10'h2A5, 2, AKC, 0, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'hB, 10'h2A5, 1, AKC, 0, 1, 1, 1, 1, 0));
    tv.push_back(v(0, 4'hB, 10'h2A5, 1, AK,  0, 1, 1, 4, 1, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 0, 0,   0, 5, 0, 0, 0, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 1, AK,  0, 1, 1, 4, 1, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 1, AKC, 0, 1, 1, 1, 1, 0));
    tv.push_back(v(0, 4'hF, 10'h2A5, 2, AKC, 32'h10, 1, 1, 0, 0, 1));
    tv.push_back(v(0, 4'hE, 10'h2A5, 1, AKC, 0, 3, 1, 32'h11, 1, 1));
    tv.push_back(v(1, 4'hE, 10'h2A5, 1, AKC, 0, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'hE, 10'h2A5, 0, 0,   0, 5, 1, 0, 0, 0));
    tv.push_back(v(0, 4'hE, 10'h2A5, 1, AKC, 0, 1, 1, 0, 1, 0));
    tv.push_back(v(0, 4'hE, 10'h2A5, 1, AK,  0, 1, 1, 1, 1, 0));
    step(1, 4'hF, 10'h0, 0, 0, 0, 0);
    step(1, 4'hF, 10'h0, 0, 0, 0, 0);
    check("reset rdata", rdata, 0);
    check("reset irq", {31'h0, irq}, 0);
    foreach (tv[i]) begin
      for (int r = 0; r < tv[i].reps; r++)
        step(tv[i].rs, tv[i].k, tv[i].s, tv[i].op == 1, tv[i].op == 2, tv[i].a, tv[i].wd);
      if (tv[i].chk) begin
        check($sformatf("vec%0d rdata", i), rdata, tv[i].ex);
        check($sformatf("vec%0d rd_hit", i), {31'h0, rd_hit}, {31'h0, tv[i].eh});
        check($sformatf("vec%0d irq", i), {31'h0, irq}, {31'h0, tv[i].ei});
      end
    end
    amap = '{ADDR_KEY, ADDR_SW, ADDR_KCTRL, ADDR_SCTRL, 32'hF000_0018};
    rk = 4'hE;
    rsw = 10'h2A5;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(7) == 0) rk[$urandom_range(3)] ^= 1'b1;
      if ($urandom_range(5) == 0) rsw[$urandom_range(9)] ^= 1'b1;
      step($urandom_range(249) == 0, rk, rsw, $urandom_range(1) == 0, $urandom_range(3) == 0,
           amap[$urandom_range(4)], $urandom);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
